// File: rtl/sub32_serial.sv
// rtl/sub32_serial.sv - byte-serial wide subtractor controller driving an external 8-bit sub8
// Latches the operands, walks bytes LSB to MSB through sub8 and chains the borrow between cycles.
module sub32_serial #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   A,
    input  logic [8*NBYTES-1:0]   B,
    input  logic                  Bin,
    output logic [8*NBYTES-1:0]   S,
    output logic                  Bout,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            sub_A,
    output logic [7:0]            sub_B,
    output logic                  sub_Bin,
    input  logic [7:0]            sub_S,
    input  logic                  sub_Bout
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    opA;
    logic [W-1:0]    opB;
    logic            brw;
    logic [IW-1:0]   idx;

    // sub8 is combinational, so the byte mux must settle within the same cycle it is consumed.
    always_comb begin
        sub_A   = 8'd0;
        sub_B   = 8'd0;
        sub_Bin = 1'b0;
        if (state == RUN) begin
            sub_A   = opA[8*idx +: 8];
            sub_B   = opB[8*idx +: 8];
            sub_Bin = brw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opA   <= '0;
            opB   <= '0;
            brw   <= 1'b0;
            idx   <= '0;
            S     <= '0;
            Bout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opA   <= A;
                        opB   <= B;
                        brw   <= Bin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    S[8*idx +: 8] <= sub_S;
                    brw           <= sub_Bout;
                    if (idx == LAST) begin
                        Bout  <= sub_Bout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    // Back-to-back request skips IDLE entirely.
                    if (start) begin
                        opA   <= A;
                        opB   <= B;
                        brw   <= Bin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub32_serial.sv
// tb/tb_sub32_serial.sv - randomized self-checking bench for sub32_serial with a behavioural sub8
module tb_sub32_serial;

    localparam int N = 4;
    localparam int W = 8 * N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          Bin = 1'b0;
    logic [W-1:0]  S;
    logic          Bout;
    logic          busy;
    logic          done;
    logic [7:0]    sub_A;
    logic [7:0]    sub_B;
    logic          sub_Bin;
    logic [7:0]    sub_S;
    logic          sub_Bout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Ripple-borrow byte subtractor: bit 8 of the 9-bit difference is the borrow-out.
    logic [8:0] diff9;
    assign diff9    = {1'b0, sub_A} - {1'b0, sub_B} - {8'd0, sub_Bin};
    assign sub_S    = diff9[7:0];
    assign sub_Bout = diff9[8];

    sub32_serial #(.NBYTES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
        .S(S), .Bout(Bout), .busy(busy), .done(done),
        .sub_A(sub_A), .sub_B(sub_B), .sub_Bin(sub_Bin),
        .sub_S(sub_S), .sub_Bout(sub_Bout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Borrow entering byte k equals whether the low k bytes of A fall short of B + Bin.
    function automatic logic borrow_into(input logic [31:0] a, input logic [31:0] b,
                                         input logic bin, input int k);
        logic [63:0] mask;
        if (k == 0) return bin;
        mask = (64'd1 << (8 * k)) - 64'd1;
        return ((64'(a) & mask) < ((64'(b) & mask) + 64'(bin)));
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                          input int poke);
        logic [63:0] exp_s;
        logic        exp_b;
        int          c;
        int          nb;
        int          extra;
        logic        got_done;
        exp_s = (64'(a) - 64'(b) - 64'(bin)) & 64'hFFFF_FFFF;
        exp_b = (64'(a) < (64'(b) + 64'(bin)));
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        c = 0; nb = 0; got_done = 1'b0;
        while (!got_done && c < 20) begin
            @(negedge clk);
            c++;
            if (c == 1) start = 1'b0;
            if (c == poke) begin
                start = 1'b1; A = $urandom; B = $urandom; Bin = 1'b1;
            end
            if (c == poke + 1) start = 1'b0;
            if (busy && nb < N) begin
                check("sub_A", sub_A, a[8*nb +: 8]);
                check("sub_B", sub_B, b[8*nb +: 8]);
                check("sub_Bin", sub_Bin, borrow_into(a, b, bin, nb));
                nb++;
            end else if (busy) begin
                nb++;
            end
            if (done) got_done = 1'b1;
        end
        check("done_seen", got_done, 1);
        check("latency", c, N + 1);
        check("busy_cycles", nb, N);
        check("S", S, exp_s);
        check("Bout", Bout, exp_b);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("quiet_after", extra, 0);
    endtask

    initial begin
        int t1;
        int t2;
        int c;
        int ndone;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (3) @(negedge clk);
        check("rst_S", S, 0);
        check("rst_Bout", Bout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sub", {sub_A, sub_B, sub_Bin}, 0);
        rst = 1'b0;

        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
        run_op(32'h0000_0100, 32'h0000_0001, 1'b1, 0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 2);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0);

        // Held start: FFFFFFFF-FFFFFFFF then 0-0, no IDLE in between.
        @(negedge clk);
        A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 32'h0; B = 32'h0;
        t1 = -1; t2 = -1; c = 1;
        while (t2 < 0 && c < 30) begin
            if (done) begin
                if (t1 < 0) begin
                    t1 = c;
                    check("b2b_S1", S, 0);
                    check("b2b_Bout1", Bout, 0);
                    @(negedge clk);
                    c++;
                    check("b2b_no_idle", busy, 1);
                    start = 1'b0;
                    continue;
                end else begin
                    t2 = c;
                    check("b2b_S2", S, 0);
                    check("b2b_Bout2", Bout, 0);
                end
            end
            if (t2 < 0) begin
                @(negedge clk);
                c++;
            end
        end
        start = 1'b0;
        check("b2b_first_at", t1, N + 1);
        check("b2b_spacing", t2 - t1, N + 1);
        repeat (3) @(negedge clk);

        // Reset while byte 2 is in flight.
        @(negedge clk);
        A = 32'h1234_5678; B = 32'h0FED_CBA9; Bin = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_S", S, 0);
        check("mid_rst_Bout", Bout, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sub", {sub_A, sub_B, sub_Bin}, 0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid_rst_no_done", ndone, 0);
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0);

        for (int k = 0; k < 30; k++) begin
            ra = $urandom;
            rb = (k % 5 == 0) ? ra : 32'($urandom);
            run_op(ra, rb, 1'($urandom_range(0, 1)), (k % 3 == 0) ? 2 + k % 3 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sub32_serial.md
# sub32_serial

Multi-cycle wide subtractor controller that sits directly upstream of the 8-bit ripple-borrow subtractor `sub8`. It latches two wide operands, feeds `sub8` one byte per clock from LSB to MSB, chains the borrow between cycles, and assembles the wide difference and final borrow-out. A wide subtraction therefore reuses a single 8-bit datapath and never needs a wider combinational chain.

## Interface

Parameters:
- `NBYTES`, default 4: operand width in bytes. W = 8*NBYTES. Legal range is 2..16.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high (ports `clk` and `rst`).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new subtraction. Sampled only in IDLE and DONE.
- `A`  in  W  minuend. Sampled on the edge that accepts `start`.
- `B`  in  W  subtrahend. Sampled on the edge that accepts `start`.
- `Bin`  in  1  initial borrow-in. Sampled on the edge that accepts `start`.
- `S`  out  W  difference A − B − Bin, modulo 2^W. Registered.
- `Bout`  out  1  final borrow-out. 1 when A < B + Bin. Registered.
- `busy`  out  1  high while an operation is in progress (RUN state).
- `done`  out  1  one-cycle pulse: `S`/`Bout` are complete.
- `sub_A`  out  8  byte to the `sub8` A input.
- `sub_B`  out  8  byte to the `sub8` B input.
- `sub_Bin`  out  1  borrow to the `sub8` Bin input.
- `sub_S`  in  8  difference byte returned by `sub8`. Combinational, same cycle.
- `sub_Bout`  in  1  borrow-out returned by `sub8`. Combinational, same cycle.

## Operation

- States:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1.
  - DONE: `done`=1 for exactly one cycle.
- IDLE → RUN when `start`=1:
  - Latch `A` into `opA` and `B` into `opB`.
  - Set borrow register `brw` ← `Bin`.
  - Set byte index `idx` ← 0.
- RUN, every cycle:
  - Drive `sub_A` = `opA[8*idx +: 8]`, `sub_B` = `opB[8*idx +: 8]`, `sub_Bin` = `brw`.
  - On the edge: `S[8*idx +: 8]` ← `sub_S`, `brw` ← `sub_Bout`, `idx` ← `idx`+1.
- RUN → DONE on the edge that processes `idx` = NBYTES−1. On that edge `Bout` ← `sub_Bout`.
- DONE → RUN if `start`=1 (back-to-back operation, same latch actions as from IDLE). Otherwise DONE → IDLE.
- `start` is ignored while in RUN. Operands and `Bin` changing during RUN have no effect.
- Outside RUN, `sub_A`, `sub_B` and `sub_Bin` are all driven to 0.
- `S` is updated in place, byte by byte, during RUN. It is guaranteed correct only from the DONE cycle until the next accepted `start`. `Bout` holds its last value until the final edge of the next operation.
- `idx` is log2-sized for NBYTES. It never wraps, because the state leaves RUN at NBYTES−1.

## Timing

- Reset values:
  - State: IDLE.
  - `S`=0, `Bout`=0, `busy`=0, `done`=0.
  - `sub_A`=0, `sub_B`=0, `sub_Bin`=0.
  - `opA`, `opB`, `brw`, `idx` all 0.
- `rst` overrides everything, including mid-RUN. The partial result is discarded and nothing is emitted afterwards.
- Latency: `start` is accepted at edge 0. Bytes are processed at edges 1..NBYTES. `done`=1 during the cycle after edge NBYTES. This is NBYTES+1 cycles from start to done.
- `busy` is high for exactly NBYTES cycles per operation.
- Throughput with `start` held high: one result every NBYTES+1 cycles.
- `sub8` is combinational, so the `sub_*` output → `sub_*` input path must close within one clock period.

## Test plan

- A=0x00000005, B=0x00000003, Bin=0 → `done` 5 cycles after start; S=0x00000002, Bout=0; `busy` high for 4 cycles.
- A=0x00000000, B=0x00000001, Bin=0 → S=0xFFFFFFFF, Bout=1. Borrow must propagate through all 4 bytes; check `sub_Bin`=1 on bytes 1–3.
- A=0x00000100, B=0x00000001, Bin=1 → S=0x000000FE, Bout=0.
- Start 0x12345678−0x11111111. Pulse `start` with different operands during RUN → the second request is ignored; S=0x01234567, Bout=0, single `done` pulse.
- Hold `start` high with 0xFFFFFFFF−0xFFFFFFFF, then 0x0−0x0 → two `done` pulses 5 cycles apart. Both give S=0, Bout=0, and IDLE is never visited between them.
- Assert `rst` during byte 2 of an operation → the next cycle shows IDLE, S=0, Bout=0, `busy`=0, and no `done` follows. A new start then completes normally.
